// File: rtl/ext_fifo_refill_ctrl_pkg.sv
// Shared widths and FSM encodings for the external-SRAM refill controller.
package ext_fifo_refill_ctrl_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_CNT_W  = 20;
    localparam int DEF_DATA_W = 36;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t IDLE  = 2'd0;
    localparam fsm_state_t BURST = 2'd1;
    localparam fsm_state_t DRAIN = 2'd2;

endpackage

// File: rtl/ext_fifo_refill_ctrl_rd_latency_pipe.sv
// LAT-deep valid shift register tracking SRAM reads still in flight.
module rd_latency_pipe
    import ext_fifo_refill_ctrl_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic wr_en,
    output logic in_flight,
    output logic last_only
);

    // Only the oldest request remains: the pipe empties on the next edge.
    localparam logic [LAT-1:0] LAST_MASK = LAT'(1 << (LAT - 1));

    logic [LAT-1:0] shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else begin
            shift[0] <= req;
            for (int i = 1; i < LAT; i++) begin
                shift[i] <= shift[i-1];
            end
        end
    end

    assign wr_en     = shift[LAT-1];
    assign in_flight = |shift;
    assign last_only = (shift == LAST_MASK);

endmodule

// File: rtl/ext_fifo_refill_ctrl.sv
// Burst-refill engine: reads SRAM in bursts once the randomized full flag drops
// and streams the fixed-latency returns into the on-chip egress FIFO.
module ext_fifo_refill_ctrl
    import ext_fifo_refill_ctrl_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int LAT       = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              full_in,
    input  logic [CNT_W-1:0]  ext_occupied,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              ext_consume,
    output logic              busy
);

    localparam logic [CNT_W-1:0] MAX_BURST = CNT_W'(BURST_LEN);

    fsm_state_t       state;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_load;
    logic             in_flight;
    logic             last_only;
    logic             drain_done;

    rd_latency_pipe #(
        .LAT(LAT)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (rd_req),
        .wr_en    (fifo_wr_en),
        .in_flight(in_flight),
        .last_only(last_only)
    );

    assign burst_load   = (ext_occupied < MAX_BURST) ? ext_occupied : MAX_BURST;
    assign rd_req       = (state == BURST);
    assign ext_consume  = rd_req;
    assign busy         = (state == BURST) || (state == DRAIN);
    assign fifo_wr_data = sram_rdata;

    // Leave DRAIN on the edge that retires the final return, so busy drops
    // the cycle after the last FIFO write.
    assign drain_done = !in_flight || last_only;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rd_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!full_in && (ext_occupied != '0)) begin
                        state     <= BURST;
                        burst_cnt <= burst_load;
                    end
                end
                BURST: begin
                    rd_addr   <= rd_addr + 1'b1;
                    burst_cnt <= burst_cnt - 1'b1;
                    if (burst_cnt == CNT_W'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    burst_cnt_live: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BURST) |-> (burst_cnt != '0));

endmodule
